dot_product_engine: RTL and testbench



---
 rtl/dotp_pkg.sv | 25 ++
 rtl/dotp_if.sv | 32 +++
 rtl/dotp_mac.sv | 45 ++++
 rtl/dot_product_engine.sv | 114 +++++++++++
 tb/tb_dot_product_engine.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/dotp_pkg.sv
// Shared types, defaults and width helpers for the dot-product engine.
package dotp_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_VETOR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic int result_width(input int data_w, input int vetor_w);
    return 2 * data_w + clog2(vetor_w);
  endfunction

endpackage

// File: rtl/dotp_if.sv
// Request, memory read port and result handshake of the dot-product engine.
interface dotp_if
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VETOR_WIDTH  = DEF_VETOR_WIDTH,
  parameter int ADDR_WIDTH   = clog2(VETOR_WIDTH * DATA_WIDTH),
  parameter int RESULT_WIDTH = result_width(DATA_WIDTH, VETOR_WIDTH)
) ();

  logic                    start;
  logic [ADDR_WIDTH-1:0]   base_addr;
  logic                    busy;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   a_data;
  logic [DATA_WIDTH-1:0]   b_data;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_valid;
  logic                    result_ready;

  modport master (
    input  start, base_addr, a_data, b_data, result_ready,
    output busy, rd_en, rd_addr, result, result_valid
  );

  modport slave (
    output start, base_addr, a_data, b_data, result_ready,
    input  busy, rd_en, rd_addr, result, result_valid
  );

endinterface

// File: rtl/dotp_mac.sv
// Unsigned multiply-accumulate on returning read data; stage-2 valid gates each add.
// sum_dat is combinational acc + current product so the top can capture the final total.
module dotp_mac
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RESULT_WIDTH = result_width(DEF_DATA_WIDTH, DEF_VETOR_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_vld,
  input  logic [DATA_WIDTH-1:0]   a_dat,
  input  logic [DATA_WIDTH-1:0]   b_dat,
  output logic [RESULT_WIDTH-1:0] sum_dat
);

  logic [RESULT_WIDTH-1:0] acc_q, acc_d;
  logic                    vld2_q, vld2_d;
  logic [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    prod    = a_dat * b_dat;
    sum_dat = acc_q + RESULT_WIDTH'(prod);
    acc_d   = acc_q;
    vld2_d  = in_vld;
    if (clr) begin
      acc_d  = '0;
      vld2_d = 1'b0;
    end else if (vld2_q) begin
      acc_d = sum_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      vld2_q <= vld2_d;
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Sequences VETOR_WIDTH shared reads to two memories and presents their unsigned dot product.
// Start-to-valid is VETOR_WIDTH+1 cycles; result is held until result_ready, start ignored while busy.
module dot_product_engine
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int VETOR_WIDTH  = DEF_VETOR_WIDTH,
  parameter int ADDR_WIDTH   = clog2(VETOR_WIDTH * DATA_WIDTH),
  parameter int RESULT_WIDTH = result_width(DATA_WIDTH, VETOR_WIDTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  dotp_if.master io
);

  localparam int CNT_W = clog2(VETOR_WIDTH + 1);

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    mac_clr;
  logic [RESULT_WIDTH-1:0] mac_sum;

  // rd_en_q doubles as stage 1 of the outstanding-read valid pipe.
  dotp_mac #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RESULT_WIDTH (RESULT_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (mac_clr),
    .in_vld  (rd_en_q),
    .a_dat   (io.a_data),
    .b_dat   (io.b_data),
    .sum_dat (mac_sum)
  );

  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    rd_en_d        = 1'b0;
    rd_addr_d      = rd_addr_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    mac_clr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d   = ISSUE;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = io.base_addr;
          cnt_d     = CNT_W'(1);
          mac_clr   = 1'b1;
        end
      end
      ISSUE: begin
        if (cnt_q == CNT_W'(VETOR_WIDTH)) begin
          state_d = DRAIN;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // The last element's product is on the read bus during this cycle.
        result_d       = mac_sum;
        result_valid_d = 1'b1;
        state_d        = HOLD;
      end
      HOLD: begin
        if (io.result_ready) begin
          result_valid_d = 1'b0;
          busy_d         = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign io.busy         = busy_q;
  assign io.rd_en        = rd_en_q;
  assign io.rd_addr      = rd_addr_q;
  assign io.result       = result_q;
  assign io.result_valid = result_valid_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench for dot_product_engine with two one-cycle-latency memory models.
module tb_dot_product_engine;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  logic [7:0] mem1 [32];
  logic [7:0] mem2 [32];

  dotp_if dif ();

  dot_product_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dif.rd_en) begin
      dif.a_data <= mem1[dif.rd_addr];
      dif.b_data <= mem2[dif.rd_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(dif.busy), 0);
    chk({tag, "_rd_en"}, 32'(dif.rd_en), 0);
    chk({tag, "_addr"},  32'(dif.rd_addr), 0);
    chk({tag, "_res"},   32'(dif.result), 0);
    chk({tag, "_vld"},   32'(dif.result_valid), 0);
  endtask

  // Start accepted on the first tick; checks address sequence, latency and result.
  task automatic run_dp(input string tag, input logic [4:0] base, input logic [17:0] exp);
    logic [4:0] ea;
    dif.start     = 1'b1;
    dif.base_addr = base;
    tick();
    dif.start = 1'b0;
    chk({tag, "_busy"}, 32'(dif.busy), 1);
    for (int k = 0; k < 4; k++) begin
      ea = base + 5'(k);
      chk({tag, "_rden"}, 32'(dif.rd_en), 1);
      chk({tag, "_addr"}, 32'(dif.rd_addr), 32'(ea));
      if (k < 3) tick();
    end
    tick();
    chk({tag, "_rden_off"}, 32'(dif.rd_en), 0);
    chk({tag, "_vld_early"}, 32'(dif.result_valid), 0);
    tick();
    chk({tag, "_vld"}, 32'(dif.result_valid), 1);
    chk({tag, "_res"}, 32'(dif.result), 32'(exp));
    if (dif.result_ready) begin
      tick();
      chk({tag, "_vld_drop"}, 32'(dif.result_valid), 0);
      chk({tag, "_busy_drop"}, 32'(dif.busy), 0);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    dif.start        = 1'b0;
    dif.base_addr    = '0;
    dif.result_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem1[i] = 8'd0;
      mem2[i] = 8'd0;
    end
    for (int i = 0; i < 4; i++) begin
      mem1[i]     = 8'(i + 1);
      mem2[i]     = 8'(i + 5);
      mem1[i + 4] = 8'd1;
      mem2[i + 4] = 8'd2;
    end

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_dp("basic", 5'd0, 18'd70);

    // Backpressure: result must hold and a start in HOLD must be dropped.
    dif.result_ready = 1'b0;
    run_dp("bp", 5'd0, 18'd70);
    for (int i = 0; i < 10; i++) begin
      dif.start = (i == 4);
      tick();
    end
    dif.start = 1'b0;
    chk("bp_hold_vld", 32'(dif.result_valid), 1);
    chk("bp_hold_res", 32'(dif.result), 70);
    chk("bp_hold_busy", 32'(dif.busy), 1);
    chk("bp_hold_rden", 32'(dif.rd_en), 0);
    dif.result_ready = 1'b1;
    tick();
    chk("bp_rel_vld", 32'(dif.result_valid), 0);
    chk("bp_rel_busy", 32'(dif.busy), 0);
    tick();
    chk("bp_no_queue_busy", 32'(dif.busy), 0);
    chk("bp_no_queue_rden", 32'(dif.rd_en), 0);

    // Reset after the second issue.
    dif.start     = 1'b1;
    dif.base_addr = 5'd0;
    tick();
    dif.start = 1'b0;
    tick();
    chk("mid_addr_before", 32'(dif.rd_addr), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    run_dp("after_rst", 5'd0, 18'd70);

    run_dp("b2b_first", 5'd0, 18'd70);
    run_dp("b2b_second", 5'd4, 18'd8);

    for (int i = 0; i < 4; i++) begin
      mem1[i] = 8'hFF;
      mem2[i] = 8'hFF;
    end
    run_dp("max", 5'd0, 18'h3F804);

    mem1[30] = 8'd2;
    mem1[31] = 8'd3;
    mem1[0]  = 8'd4;
    mem1[1]  = 8'd5;
    mem2[30] = 8'd1;
    mem2[31] = 8'd1;
    mem2[0]  = 8'd1;
    mem2[1]  = 8'd1;
    run_dp("wrap", 5'd30, 18'd14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
